// File: rtl/aes_round_sched.sv
// Iterative AES-128 round sequencer: drives one shared round-function datapath and an
// external key-step unit, counting ROUND_LAT cycles per round since the datapath has no handshake.
module aes_round_sched #(
  parameter int ROUND_LAT  = 2,
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_block,
  input  logic [127:0] s_key,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic [127:0] rf_block,
  output logic [127:0] rf_key,
  output logic         rf_last,
  input  logic [127:0] rf_result,
  output logic [127:0] ks_key,
  output logic [7:0]   ks_rcon,
  input  logic [127:0] ks_next,
  output logic         busy,
  output logic [3:0]   round_o
);

  localparam int            CW         = (ROUND_LAT < 1) ? 1 : $clog2(ROUND_LAT + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(ROUND_LAT);
  localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t        state;
  logic [127:0]  state_q;
  logic [127:0]  key_q;
  logic [7:0]    rcon_q;
  logic [CW-1:0] cnt;
  logic [3:0]    round;

  assign rf_block = state_q;
  assign rf_key   = ks_next;
  assign ks_key   = key_q;
  assign ks_rcon  = rcon_q;
  assign round_o  = round;

  // m_valid is raised one cycle after entering DONE, so the result appears
  // NUM_ROUNDS*(ROUND_LAT+1)+1 cycles after the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      rf_last <= 1'b0;
      m_data  <= '0;
      state_q <= '0;
      key_q   <= '0;
      rcon_q  <= 8'h01;
      cnt     <= '0;
      round   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            state_q <= s_block ^ s_key;
            key_q   <= s_key;
            rcon_q  <= 8'h01;
            round   <= 4'd1;
            cnt     <= '0;
            rf_last <= (LAST_ROUND == 4'd1);
            s_ready <= 1'b0;
            busy    <= 1'b1;
            state   <= ROUND;
          end
        end
        ROUND: begin
          if (cnt == CNT_MAX) begin
            state_q <= rf_result;
            key_q   <= ks_next;
            cnt     <= '0;
            rcon_q  <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            if (round == LAST_ROUND) begin
              m_data  <= rf_result;
              round   <= '0;
              rf_last <= 1'b0;
              state   <= DONE;
            end else begin
              round   <= round + 4'd1;
              rf_last <= ((round + 4'd1) == LAST_ROUND);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            m_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
